// File: rtl/stream_pkg.sv
// Shared constants and helpers for the credit-based stream transmitter.
package stream_pkg;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned SKID_DEPTH  = 2;

    // Width needed to hold the values 0..max_credits
    function automatic int unsigned credit_w(input int unsigned max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating link credit counter with a sticky overflow flag.
module credit_counter
    import stream_pkg::*;
#(
    parameter  int unsigned MAX_CREDITS = 4,
    localparam int unsigned CNT_W       = credit_w(MAX_CREDITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             has_credit,
    output logic             err_overflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             has_credit_q, has_credit_d;
    logic             err_q, err_d;

    // dec is only asserted while has_credit is set, so no underflow path is needed
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (inc && !dec) begin
            if (cnt_q == CNT_W'(MAX_CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        has_credit_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= CNT_W'(MAX_CREDITS);
            has_credit_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            has_credit_q <= has_credit_d;
            err_q        <= err_d;
        end
    end

    assign cnt          = cnt_q;
    assign has_credit   = has_credit_q;
    assign err_overflow = err_q;

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-gated link transmitter fed through a 2-entry registered-ready buffer.
// Optional stall statistics counter enabled by defining CREDIT_TX_STATS_EN.
module stream_credit_tx
    import stream_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 8,
    parameter  int unsigned MAX_CREDITS = 4,
    localparam int unsigned CNT_W       = credit_w(MAX_CREDITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_s,
    output logic                   ready_s,
    input  logic [DATA_WIDTH-1:0]  data_s,
    output logic                   tx_valid,
    output logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   credit_ret,
    output logic [CNT_W-1:0]       credit_cnt,
    output logic                   err_overflow
`ifdef CREDIT_TX_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int unsigned FILL_W = $clog2(SKID_DEPTH + 1);

    logic [DATA_WIDTH-1:0] ent_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] ent_d [SKID_DEPTH];
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  ready_q, ready_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  has_credit;
    logic                  accept_c;
    logic                  launch_c;

    assign accept_c = valid_s && ready_q;
    assign launch_c = (fill_q != '0) && has_credit;

    credit_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .dec          (launch_c),
        .inc          (credit_ret),
        .cnt          (credit_cnt),
        .has_credit   (has_credit),
        .err_overflow (err_overflow)
    );

    // Pop the head before appending so a full-rate accept+launch keeps order
    always_comb begin
        ent_d      = ent_q;
        fill_d     = fill_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (launch_c) begin
            ent_d[0]   = ent_q[1];
            fill_d     = fill_q - FILL_W'(1);
            tx_valid_d = 1'b1;
            tx_data_d  = ent_q[0];
        end
        if (accept_c) begin
            ent_d[fill_d[0]] = data_s;
            fill_d           = fill_d + FILL_W'(1);
        end
        ready_d = (fill_d <= FILL_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            fill_q     <= '0;
            ready_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            ent_q      <= ent_d;
            fill_q     <= fill_d;
            ready_q    <= ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign ready_s  = ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

`ifdef CREDIT_TX_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    // Cycles where a beat is waiting but the link has no credit
    always_comb begin
        stall_d = stall_q;
        if ((fill_q != '0) && !has_credit && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_stream_credit_tx.sv
// Self-checking bench for stream_credit_tx against a queue-based reference model.
module tb_stream_credit_tx;

    localparam int unsigned DW  = 8;
    localparam int unsigned MAX = 4;
    localparam int unsigned CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_s;
    logic          ready_s;
    logic [DW-1:0] data_s;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_ret;
    logic [CW-1:0] credit_cnt;
    logic          err_overflow;
`ifdef CREDIT_TX_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    stream_credit_tx #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_s      (valid_s),
        .ready_s      (ready_s),
        .data_s       (data_s),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .credit_ret   (credit_ret),
        .credit_cnt   (credit_cnt),
        .err_overflow (err_overflow)
`ifdef CREDIT_TX_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: beats held, credits, and expected registered outputs
    logic [DW-1:0] mq[$];
    int unsigned   m_cred;
    bit            m_ready, m_txv, m_err;
    logic [DW-1:0] m_txd;
    int unsigned   m_stall;

    int  n_cmp = 0;
    int  n_err = 0;
    int  pulses = 0;
    bit  last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cred  = MAX;
        m_ready = 1'b0;
        m_txv   = 1'b0;
        m_txd   = '0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    // One clock: apply inputs, advance model by the link rules, compare all outputs
    task automatic step(input bit v, input logic [DW-1:0] d, input bit cr);
        bit acc, lau;
        valid_s    = v;
        data_s     = d;
        credit_ret = cr;
        acc = v && m_ready;
        lau = (mq.size() != 0) && (m_cred != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            last_acc = 1'b0;
        end else begin
            if (mq.size() != 0 && m_cred == 0 && m_stall != 32'hFFFF) m_stall++;
            m_txv = lau;
            if (lau) m_txd = mq.pop_front();
            if (acc) mq.push_back(d);
            if (lau && !cr) m_cred--;
            else if (cr && !lau) begin
                if (m_cred == MAX) m_err = 1'b1;
                else m_cred++;
            end
            m_ready  = (mq.size() <= 1);
            last_acc = acc;
        end
        if (tx_valid === 1'b1) pulses++;
        chk("ready_s", 32'(ready_s), 32'(m_ready));
        chk("tx_valid", 32'(tx_valid), 32'(m_txv));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("credit_cnt", 32'(credit_cnt), m_cred);
        chk("err_overflow", 32'(err_overflow), 32'(m_err));
`ifdef CREDIT_TX_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall);
`endif
    endtask

    initial begin
        int sent;
        int guard;
        bit cr;
        rst = 1'b1; valid_s = 1'b0; data_s = '0; credit_ret = 1'b0;
        model_reset();

        // Reset held three cycles, then ready rises at the first edge after release
        repeat (3) step(1'b0, '0, 1'b0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("rel_ready", 32'(ready_s), 32'd1);
        chk("rel_cnt", 32'(credit_cnt), 32'd4);
        chk("rel_txv", 32'(tx_valid), 32'd0);

        // Six back-to-back beats with no credit return
        pulses = 0; sent = 0; guard = 0;
        while (sent < 6 && guard < 40) begin
            step(1'b1, DW'(sent + 1), 1'b0);
            if (last_acc) sent++;
            guard++;
        end
        chk("p2_accepted", 32'(sent), 32'd6);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("p2_pulses", 32'(pulses), 32'd4);
        chk("p2_cnt", 32'(credit_cnt), 32'd0);
        chk("p2_ready", 32'(ready_s), 32'd0);
`ifdef CREDIT_TX_STATS_EN
        chk("p2_stall_nz", 32'(stall_cnt != 16'd0), 32'd1);
`endif

        // Two credit returns release the two stalled beats
        pulses = 0;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("p3_last_data", 32'(tx_data), 32'h06);
        repeat (3) step(1'b0, '0, 1'b0);
        chk("p3_pulses", 32'(pulses), 32'd2);
        chk("p3_cnt", 32'(credit_cnt), 32'd0);
        chk("p3_ready", 32'(ready_s), 32'd1);

        // Refill to MAX, then 20 cycles of launch paired with credit return
        repeat (4) step(1'b0, '0, 1'b1);
        chk("p4_refill", 32'(credit_cnt), 32'd4);
        step(1'b1, DW'($urandom), 1'b0);
        pulses = 0;
        repeat (20) step(1'b1, DW'($urandom), 1'b1);
        chk("p4_pulses", 32'(pulses), 32'd20);
        chk("p4_cnt", 32'(credit_cnt), 32'd4);
        chk("p4_err", 32'(err_overflow), 32'd0);
        step(1'b0, '0, 1'b1);
        repeat (2) step(1'b0, '0, 1'b0);

        // Overflow: credit returned while already full is sticky
        step(1'b0, '0, 1'b1);
        chk("p5_cnt", 32'(credit_cnt), 32'd4);
        chk("p5_err", 32'(err_overflow), 32'd1);
        repeat (5) step(1'b0, '0, 1'b0);
        chk("p5_err_sticky", 32'(err_overflow), 32'd1);

        // Stall with two buffered beats, restore one credit, then reset
        sent = 0; guard = 0;
        while (sent < 6 && guard < 40) begin
            step(1'b1, DW'(8'hA0 + sent), 1'b0);
            if (last_acc) sent++;
            guard++;
        end
        chk("p6_accepted", 32'(sent), 32'd6);
        step(1'b0, '0, 1'b1);
        chk("p6_pre_cnt", 32'(credit_cnt), 32'd1);
        chk("p6_pre_full", 32'(ready_s), 32'd0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("p6_txv", 32'(tx_valid), 32'd0);
        chk("p6_cnt", 32'(credit_cnt), 32'd4);
        chk("p6_err_clr", 32'(err_overflow), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (6) step(1'b0, '0, 1'b0);
        chk("p6_no_stale", 32'(pulses), 32'd0);

        // Random traffic; credits returned only for beats in flight, rare stray returns
        repeat (400) begin
            cr = ((m_cred < MAX) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 63) == 0);
            step(($urandom_range(0, 3) != 0), DW'($urandom), cr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
